// File: rtl/vcarry_seq.sv
// Vector add/subtract with carry/borrow (vadc, vsbc, vmadc, vmsbc), processed one element at a time.
// Latency: 3 cycles per element with rd_ack already high; done arrives 3*vl+1 cycles after start.
// Backpressure: the READ state holds rd_req until rd_ack arrives, and start is ignored unless idle.
module vcarry_seq #(
    parameter int VLMAX = 8,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       funct,
    input  logic             use_carry,
    input  logic [IW:0]      vl,
    input  logic [VLMAX-1:0] v0_mask,
    output logic             rd_req,
    input  logic             rd_ack,
    output logic [IW-1:0]    elem_idx,
    input  logic [31:0]      a_elem,
    input  logic [31:0]      b_elem,
    output logic             wr_en,
    output logic [IW-1:0]    wr_idx,
    output logic [31:0]      wr_data,
    output logic             mask_we,
    output logic [VLMAX-1:0] mask_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, FIN} state_t;

    localparam logic [IW:0] VLMAX_W = (IW+1)'(VLMAX);

    state_t           state;
    logic [1:0]       funct_q;     // [1]: mask-producing form, [0]: subtract
    logic             uc_q;
    logic [VLMAX-1:0] v0_q;
    logic [IW:0]      vl_q;
    logic [IW:0]      idx;         // one bit wider than elem_idx so it can reach vl=VLMAX
    logic [VLMAX-1:0] acc;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      s_q;
    logic             cout_q;

    logic [IW:0]      vl_clamp;
    logic [IW:0]      idx_nxt;
    logic             carry_in;
    logic [32:0]      sum33;
    logic [31:0]      dif32;
    logic             borrow;
    logic [VLMAX-1:0] len_mask;

    assign vl_clamp = (vl > VLMAX_W) ? VLMAX_W : vl;
    assign idx_nxt  = idx + 1'b1;
    assign carry_in = uc_q & v0_q[idx[IW-1:0]];
    assign sum33    = {1'b0, a_q} + {1'b0, b_q} + {32'b0, carry_in};
    assign dif32    = a_q - b_q - {31'b0, carry_in};
    assign borrow   = ({1'b0, a_q} < ({1'b0, b_q} + {32'b0, carry_in}));

    assign busy     = (state != IDLE);
    assign elem_idx = idx[IW-1:0];

    // Bits at or above the active length are forced to zero in the written mask.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < VLMAX; i++) begin
            if (i < int'(vl_q)) len_mask[i] = 1'b1;
        end
    end

    // Element sequencer; every output pulse is registered here.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            funct_q  <= 2'b00;
            uc_q     <= 1'b0;
            v0_q     <= '0;
            vl_q     <= '0;
            idx      <= '0;
            acc      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            rd_req   <= 1'b0;
            wr_en    <= 1'b0;
            wr_idx   <= '0;
            wr_data  <= '0;
            mask_we  <= 1'b0;
            mask_out <= '0;
            done     <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            mask_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    // done is still high in the first idle cycle; a start then is dropped.
                    if (start && !done) begin
                        funct_q <= funct;
                        uc_q    <= use_carry;
                        v0_q    <= v0_mask;
                        vl_q    <= vl_clamp;
                        idx     <= '0;
                        acc     <= '0;
                        if (vl_clamp == '0) begin
                            state <= FIN;
                        end else begin
                            state  <= READ;
                            rd_req <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_ack) begin
                        a_q    <= a_elem;
                        b_q    <= b_elem;
                        rd_req <= 1'b0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    s_q    <= funct_q[0] ? dif32 : sum33[31:0];
                    cout_q <= funct_q[0] ? borrow : sum33[32];
                    state  <= WRITE;
                end
                WRITE: begin
                    if (!funct_q[1]) begin
                        wr_en   <= 1'b1;
                        wr_idx  <= idx[IW-1:0];
                        wr_data <= s_q;
                    end else begin
                        acc[idx[IW-1:0]] <= cout_q;
                    end
                    idx <= idx_nxt;
                    if (idx_nxt == vl_q) begin
                        state <= FIN;
                    end else begin
                        state  <= READ;
                        rd_req <= 1'b1;
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    if (funct_q[1]) begin
                        mask_we  <= 1'b1;
                        mask_out <= acc & len_mask;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vcarry_seq.sv
// Directed bench for vcarry_seq: carry/borrow results, mask writes, timing, stalls, reset abort.
// Cycle counts are taken from the edge that samples start.
// rd_ack is tied high except during the stall scenario.
module tb_vcarry_seq;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [1:0]  funct;
    logic        use_carry;
    logic [3:0]  vl;
    logic [7:0]  v0_mask;
    logic        rd_req;
    logic        rd_ack;
    logic [2:0]  elem_idx;
    logic [31:0] a_elem;
    logic [31:0] b_elem;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic        mask_we;
    logic [7:0]  mask_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;

    int          d_cyc, w_first, w_cnt, m_cnt, r_cnt;
    logic [31:0] w_dat;
    logic [7:0]  m_out;

    vcarry_seq #(.VLMAX(8), .IW(3)) dut (
        .clk(clk), .clrn(clrn), .start(start), .funct(funct), .use_carry(use_carry),
        .vl(vl), .v0_mask(v0_mask), .rd_req(rd_req), .rd_ack(rd_ack), .elem_idx(elem_idx),
        .a_elem(a_elem), .b_elem(b_elem), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .mask_we(mask_we), .mask_out(mask_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Pulse start for one cycle; returns half a cycle after the sampling edge (cycle 0).
    task automatic start_op(input logic [1:0] f, input logic uc, input logic [3:0] v,
                            input logic [7:0] m);
        @(negedge clk);
        funct = f; use_carry = uc; vl = v; v0_mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Watch up to budget cycles, stopping at done; done cycle stays -1 if it never comes.
    task automatic measure(input int budget, output int done_cyc, output int wr_first,
                           output int wr_cnt, output int mwe_cnt, output int rdq_cnt,
                           output logic [31:0] wdat, output logic [7:0] mout);
        done_cyc = -1; wr_first = -1; wr_cnt = 0; mwe_cnt = 0; rdq_cnt = 0;
        wdat = 32'hxxxxxxxx; mout = 8'hxx;
        for (int e = 1; e <= budget; e++) begin
            @(negedge clk);
            if (wr_en) begin
                if (wr_first < 0) wr_first = e;
                wr_cnt++;
                wdat = wr_data;
            end
            if (mask_we) begin
                mwe_cnt++;
                mout = mask_out;
            end
            if (rd_req) rdq_cnt++;
            if (done) begin
                done_cyc = e;
                break;
            end
        end
    endtask

    initial begin
        clrn = 1'b0; start = 1'b0; funct = 2'b00; use_carry = 1'b0; vl = 4'd0;
        v0_mask = 8'h00; rd_ack = 1'b1; a_elem = 32'h0; b_elem = 32'h0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_outs", {26'b0, rd_req, wr_en, mask_we, done, 2'b0}, 32'd0);
        chk("rst_idx", {26'b0, elem_idx, wr_idx}, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_mask", {24'b0, mask_out}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;

        // vadc with carry-in: FFFFFFFF + 0 + 1 wraps to 0
        a_elem = 32'hFFFFFFFF; b_elem = 32'h0;
        start_op(2'b00, 1'b1, 4'd1, 8'h01);
        chk("adc_busy", {31'b0, busy}, 32'd1);
        chk("adc_rdreq", {31'b0, rd_req}, 32'd1);
        measure(50, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("adc_wr_cyc", w_first, 32'd3);
        chk("adc_wr_cnt", w_cnt, 32'd1);
        chk("adc_wdata", w_dat, 32'h00000000);
        chk("adc_done_cyc", d_cyc, 32'd4);
        chk("adc_no_mwe", m_cnt, 32'd0);
        // start during the done cycle must not launch anything
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_done_busy", {31'b0, busy}, 32'd0);
        chk("start_at_done_rdreq", {31'b0, rd_req}, 32'd0);

        // vmadc, 6 identical elements all producing carry-out
        start_op(2'b10, 1'b1, 4'd6, 8'hFF);
        measure(50, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("madc_done_cyc", d_cyc, 32'd19);
        chk("madc_no_wr", w_cnt, 32'd0);
        chk("madc_mwe", m_cnt, 32'd1);
        chk("madc_mask", {24'b0, m_out}, 32'h3F);

        // vsbc / vmsbc with 0 - 0 - borrow
        a_elem = 32'h0; b_elem = 32'h0;
        start_op(2'b01, 1'b1, 4'd1, 8'h01);
        measure(50, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("sbc_wdata", w_dat, 32'hFFFFFFFF);
        chk("sbc_done_cyc", d_cyc, 32'd4);
        start_op(2'b11, 1'b1, 4'd1, 8'h01);
        measure(50, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("msbc_mask", {24'b0, m_out}, 32'h01);
        chk("msbc_no_wr", w_cnt, 32'd0);
        start_op(2'b01, 1'b0, 4'd1, 8'h01);
        measure(50, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("sbc_nc_wdata", w_dat, 32'h0);
        chk("sbc_nc_wr_cnt", w_cnt, 32'd1);
        start_op(2'b11, 1'b0, 4'd1, 8'h01);
        measure(50, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("msbc_nc_mask", {24'b0, m_out}, 32'h00);

        // vl = 0: straight to done
        start_op(2'b10, 1'b1, 4'd0, 8'hFF);
        chk("vl0_rdreq0", {31'b0, rd_req}, 32'd0);
        measure(50, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("vl0_done_cyc", d_cyc, 32'd1);
        chk("vl0_rdreq", r_cnt, 32'd0);
        chk("vl0_wr", w_cnt, 32'd0);
        chk("vl0_mask", {24'b0, m_out}, 32'h00);

        // vl above VLMAX clamps to 8 elements: 1 + 2 with no carry = 3
        a_elem = 32'd1; b_elem = 32'd2;
        start_op(2'b00, 1'b0, 4'd15, 8'h00);
        measure(100, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("clamp_done_cyc", d_cyc, 32'd25);
        chk("clamp_wr_cnt", w_cnt, 32'd8);
        chk("clamp_wdata", w_dat, 32'd3);

        // rd_ack stall on element 2, plus a stray start while busy
        a_elem = 32'd5; b_elem = 32'd7;
        start_op(2'b00, 1'b1, 4'd4, 8'b0000_1010);
        repeat (6) @(negedge clk);
        chk("stall_prev_wr", {31'b0, wr_en}, 32'd1);
        chk("stall_prev_wdata", wr_data, 32'd13);
        rd_ack = 1'b0; start = 1'b1; funct = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("stall_idx", {29'b0, elem_idx}, 32'd2);
            chk("stall_rdreq", {31'b0, rd_req}, 32'd1);
        end
        rd_ack = 1'b1; funct = 2'b00;
        measure(50, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("stall_done_cyc", d_cyc, 32'd7);
        chk("stall_wr_cnt", w_cnt, 32'd2);
        chk("stall_wdata", w_dat, 32'd13);
        chk("stall_no_mwe", m_cnt, 32'd0);

        // reset during WRITE of element 3 of an 8-element vmadc
        a_elem = 32'hFFFFFFFF; b_elem = 32'h0;
        start_op(2'b10, 1'b1, 4'd8, 8'hFF);
        repeat (11) @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_outs", {28'b0, rd_req, wr_en, mask_we, done}, 32'd0);
        chk("arst_data", wr_data, 32'd0);
        chk("arst_idx", {26'b0, elem_idx, wr_idx}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        measure(40, d_cyc, w_first, w_cnt, m_cnt, r_cnt, w_dat, m_out);
        chk("arst_no_done", d_cyc, 32'hFFFFFFFF);
        chk("arst_no_mwe", m_cnt, 32'd0);
        chk("arst_no_wr", w_cnt, 32'd0);
        chk("arst_no_rdreq", r_cnt, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vcarry_seq.md
VCARRY_SEQ -- requirements
Module: vcarry_seq

Interface
REQ-001 SHALL have parameter VLMAX, default 8, giving the maximum element count at e32/m1.
REQ-002 SHALL have parameter IW, default 3, giving the element index width, log2(VLMAX).
REQ-003 SHALL have port clk, input, 1, as the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clrn, input, 1, as the asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to execute one vector carry instruction.
REQ-006 SHALL have port funct, input, 2, where 00=vadc, 01=vsbc, 10=vmadc, 11=vmsbc.
REQ-007 SHALL have port use_carry, input, 1, where 1 takes carry/borrow-in from v0 (the *m forms) and 0 forces it to 0.
REQ-008 SHALL have port vl, input, IW+1, the active vector length from vsetvli.
REQ-009 SHALL have port v0_mask, input, VLMAX, the v0 mask bits.
REQ-010 SHALL have port rd_req, output, 1, an operand read request to the vector register file.
REQ-011 SHALL have port rd_ack, input, 1, indicating a_elem and b_elem are valid this cycle.
REQ-012 SHALL have port elem_idx, output, IW, the element index being read.
REQ-013 SHALL have ports a_elem and b_elem, input, 32 each, the vs2 element and the vs1/rs1/imm element.
REQ-014 SHALL have ports wr_en (output, 1), wr_idx (output, IW) and wr_data (output, 32) for the vd element write.
REQ-015 SHALL have ports mask_we (output, 1) and mask_out (output, VLMAX) for the vd mask write.
REQ-016 SHALL have ports busy (output, 1) and done (output, 1).

Function
REQ-017 SHALL implement FSM states IDLE, READ, EXEC, WRITE, FIN.
REQ-018 In IDLE, start=1 SHALL latch funct, use_carry, v0_mask and min(vl,VLMAX), clear idx and the mask accumulator, then go to READ, or to FIN if vl=0.
REQ-019 start SHALL be ignored while busy; busy=1 in every state except IDLE.
REQ-020 READ SHALL hold rd_req=1 with elem_idx=idx until rd_ack=1, then capture both operands and go to EXEC; with no rd_ack it stays in READ indefinitely.
REQ-021 EXEC SHALL compute c = use_carry & v0_mask[idx], using 33-bit arithmetic.
REQ-022 For add functs, EXEC SHALL compute {co,s} = a+b+c; for subtract functs, s = a-b-c and bo = ({1'b0,a} < {1'b0,b}+c).
REQ-023 WRITE for vadc/vsbc SHALL pulse wr_en=1 for exactly one cycle, with wr_idx=idx and wr_data=s.
REQ-024 WRITE for vmadc/vmsbc SHALL set accumulator bit idx to co or bo, with no wr_en.
REQ-025 After WRITE, idx SHALL increment; idx=vl goes to FIN, otherwise to READ.
REQ-026 Per-element latency SHALL be 3 cycles when rd_ack is already high; total start-to-done is 3*vl+1 cycles.
REQ-027 FIN SHALL pulse done=1 for one cycle; for mask functs it SHALL also pulse mask_we=1 with mask_out = accumulator and bits >= vl equal to 0; then it returns to IDLE.
REQ-028 A start arriving in the same cycle as done SHALL be ignored; a new start is accepted only from IDLE.
REQ-029 vl > VLMAX SHALL be clamped to VLMAX; idx SHALL never wrap.
REQ-030 rd_req, wr_en, mask_we and done SHALL be registered, glitch-free outputs.

Reset
REQ-031 clrn=0 SHALL immediately force state IDLE, idx=0, accumulator=0, and all outputs 0 (rd_req, wr_en, mask_we, done, busy, elem_idx, wr_idx, wr_data, mask_out).
REQ-032 A reset mid-instruction SHALL abort it with no further wr_en or mask_we, and none after clrn is released.

Verification
REQ-033 vadc, use_carry=1, vl=1, a=FFFFFFFF, b=0, v0_mask[0]=1, rd_ack tied 1 -> wr_en at cycle 3 with wr_data=00000000, done at cycle 4.
REQ-034 vmadc, same operands, vl=6 with all elements identical -> no wr_en, mask_we with mask_out=00111111b, done at cycle 19.
REQ-035 vsbc, use_carry=1, a=0, b=0, v0=1 -> wr_data=FFFFFFFF; the same case with vmsbc -> mask bit 1; with use_carry=0 -> wr_data 0 and bit 0.
REQ-036 vl=0 start -> done one cycle later, with no rd_req and no wr_en; for vmadc, mask_out=0.
REQ-037 rd_ack held low 5 cycles on element 2 -> elem_idx stays 2 and rd_req stays high; a start pulse while busy leaves the result unchanged.
REQ-038 clrn pulsed low during WRITE of element 3 of vl=8 -> outputs 0 at once, state IDLE, no mask_we afterwards.
